cmd_unpacker: RTL and testbench

//  Sits between the Ethernet/UDP payload receiver and cmd_parser. Takes the command payload
//  as a byte stream and splits it into 6-byte address/data records. Buffers the records in a

---
 rtl/cmd_unpacker_pkg.sv | 22 ++
 rtl/cmd_unpacker_fifo.sv | 49 ++++
 rtl/cmd_unpacker.sv | 142 ++++++++++++++
 tb/tb_cmd_unpacker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_unpacker_pkg.sv
// Shared types for the command unpacker: record layout, FSM encodings and
// a saturating add for the error counter.
package cmd_unpacker_pkg;

  localparam int CMD_REC_BYTES = 6;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_rec_t;

  // The MAGIC check is made on the sop byte itself, so it needs no state of its own.
  typedef enum logic [1:0] {IN_HUNT, IN_REC, IN_DROP} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_SETUP, OUT_STROBE, OUT_GAP} out_state_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/cmd_unpacker_fifo.sv
// Synchronous record FIFO with a registered occupancy count; DEPTH must be a power of 2.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr & ~full;
  assign do_rd   = rd & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cmd_unpacker.sv
// Splits a MAGIC-prefixed payload byte stream into 6-byte addr/data records,
// queues them, and replays each as a SETUP / WREN strobe / GAP sequence.
module cmd_unpacker
  import cmd_unpacker_pkg::*;
#(
  parameter logic [7:0] MAGIC      = 8'h5A,
  parameter int         FIFO_DEPTH = 8,
  parameter int         WREN_CYC   = 2,
  parameter int         GAP_CYC    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_sop,
  input  logic        i_eop,
  output logic        o_ready,
  output logic [15:0] o_cmd_addr,
  output logic [31:0] o_cmd_data,
  output logic        o_cmd_wren,
  output logic        o_busy,
  output logic [7:0]  o_err_cnt
);
  localparam logic [2:0] LAST_IDX = 3'(CMD_REC_BYTES - 1);

  in_state_t  in_st;
  out_state_t out_st;
  logic [2:0] idx;
  logic [39:0] asm_q;
  logic       push_vld;
  cmd_rec_t   push_rec, head;
  logic       fifo_full, fifo_empty, pop, take;
  logic [1:0] err_inc;
  logic [7:0] cnt;

  assign take    = i_valid & o_ready;
  assign o_ready = ~fifo_full;
  assign pop     = (out_st == OUT_IDLE) & ~fifo_empty;
  assign o_busy  = ~fifo_empty | (out_st != OUT_IDLE);

  // A sop byte can both truncate a partial record and fail the magic check.
  always_comb begin
    err_inc = 2'd0;
    if (take) begin
      if (i_sop) begin
        if (in_st == IN_REC && idx != 3'd0) err_inc = err_inc + 2'd1;
        if (i_data != MAGIC)                err_inc = err_inc + 2'd1;
      end else if (in_st == IN_REC && i_eop && idx != LAST_IDX) begin
        err_inc = 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_st     <= IN_HUNT;
      idx       <= '0;
      asm_q     <= '0;
      push_vld  <= 1'b0;
      push_rec  <= '0;
      o_err_cnt <= '0;
    end else begin
      push_vld  <= 1'b0;
      o_err_cnt <= sat_add8(o_err_cnt, err_inc);
      if (take) begin
        if (i_sop) begin
          idx   <= '0;
          in_st <= i_eop ? IN_HUNT : ((i_data == MAGIC) ? IN_REC : IN_DROP);
        end else begin
          case (in_st)
            IN_REC: begin
              asm_q <= {asm_q[31:0], i_data};
              if (idx == LAST_IDX) begin
                push_vld <= 1'b1;
                push_rec <= {asm_q, i_data};
                idx      <= '0;
              end else begin
                idx <= idx + 3'd1;
              end
              if (i_eop) begin
                in_st <= IN_HUNT;
                idx   <= '0;
              end
            end
            IN_DROP: if (i_eop) in_st <= IN_HUNT;
            IN_HUNT: ;
            default: in_st <= IN_HUNT;
          endcase
        end
      end
    end
  end

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(cmd_rec_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (push_vld),
    .wr_data (push_rec),
    .rd      (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_st     <= OUT_IDLE;
      o_cmd_addr <= '0;
      o_cmd_data <= '0;
      o_cmd_wren <= 1'b0;
      cnt        <= '0;
    end else begin
      case (out_st)
        OUT_IDLE: if (pop) begin
          o_cmd_addr <= head.addr;
          o_cmd_data <= head.data;
          out_st     <= OUT_SETUP;
        end
        OUT_SETUP: begin
          o_cmd_wren <= 1'b1;
          cnt        <= 8'(WREN_CYC - 1);
          out_st     <= OUT_STROBE;
        end
        OUT_STROBE: begin
          if (cnt == '0) begin
            o_cmd_wren <= 1'b0;
            cnt        <= 8'(GAP_CYC - 1);
            out_st     <= OUT_GAP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        OUT_GAP: begin
          if (cnt == '0) out_st <= OUT_IDLE;
          else           cnt    <= cnt - 8'd1;
        end
        default: out_st <= OUT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_unpacker.sv
// Scoreboard bench: packets are built from descriptors, expected records/errors
// are queued at build time and a monitor checks every strobe as it appears.
module tb_cmd_unpacker;
  localparam logic [7:0] MAGIC = 8'h5A;
  localparam int DEPTH = 4;
  localparam int WREN  = 2;
  localparam int GAP   = 12;
  localparam int TPUT  = 2 + WREN + GAP;

  logic clk = 0, rst = 1;
  logic [7:0] i_data = 0;
  logic i_valid = 0, i_sop = 0, i_eop = 0;
  logic o_ready, o_cmd_wren, o_busy;
  logic [15:0] o_cmd_addr;
  logic [31:0] o_cmd_data;
  logic [7:0] o_err_cnt;

  cmd_unpacker #(.MAGIC(MAGIC), .FIFO_DEPTH(DEPTH), .WREN_CYC(WREN), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
    .o_ready(o_ready), .o_cmd_addr(o_cmd_addr), .o_cmd_data(o_cmd_data),
    .o_cmd_wren(o_cmd_wren), .o_busy(o_busy), .o_err_cnt(o_err_cnt));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, rise_cnt = 0, last_rise = 0, last_acc = 0, tput_prev = 0;
  int exp_err = 0;
  bit tput_chk = 0, saw_full = 0;
  logic [47:0] exp_q[$];
  logic [9:0]  pkt[$];  // {sop, eop, data}

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: samples just after each rising edge.
  initial begin
    logic [47:0] cur;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;
    bit have_cur, prev_wren;
    int hi_run, lo_run;
    have_cur = 0; prev_wren = 0; hi_run = 0; lo_run = 1000;
    prev_addr = 0; prev_data = 0; cur = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        exp_q.delete();
        have_cur = 0; prev_wren = 0; hi_run = 0; lo_run = 1000; tput_prev = 0;
        continue;
      end
      if (o_cmd_wren && !prev_wren) begin
        rise_cnt++;
        last_rise = cyc;
        if (tput_chk && tput_prev != 0) check("throughput", cyc - tput_prev, TPUT);
        tput_prev = cyc;
        check("gap_min", lo_run >= GAP, 1);
        hi_run = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
          have_cur = 0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          check("setup_addr", prev_addr, cur[47:32]);
          check("setup_data", prev_data, cur[31:0]);
        end
      end
      if (o_cmd_wren) begin
        hi_run++;
        if (have_cur) check("strobe_rec", {o_cmd_addr, o_cmd_data}, cur);
      end else begin
        if (prev_wren) begin
          check("wren_width", hi_run, WREN);
          lo_run = 0;
        end
        lo_run++;
        if (have_cur && lo_run <= GAP) check("gap_rec", {o_cmd_addr, o_cmd_data}, cur);
      end
      prev_wren = o_cmd_wren;
      prev_addr = o_cmd_addr;
      prev_data = o_cmd_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Driver sits just after a falling edge between calls.
  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int g = 0;
    i_valid = 1; i_data = d; i_sop = s; i_eop = e;
    while (!o_ready && g < 3000) begin
      saw_full = 1;
      g++;
      @(negedge clk);
    end
    if (g >= 3000) check("ready_timeout", 0, 1);
    last_acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_valid = 0;
    repeat (n) begin
      i_sop = 1'($urandom); i_eop = 1'($urandom); i_data = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_pkt(input bit bubbles);
    for (int i = 0; i < pkt.size(); i++) begin
      send_byte(pkt[i][7:0], pkt[i][9], pkt[i][8]);
      if (bubbles && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    i_valid = 0;
  endtask

  task automatic build_good(input int nrec, input int extra, input bit term);
    logic [47:0] r;
    pkt.delete();
    pkt.push_back({2'b00, MAGIC});
    for (int i = 0; i < nrec; i++) begin
      r = {16'($urandom), 32'($urandom)};
      exp_q.push_back(r);
      for (int j = 5; j >= 0; j--) pkt.push_back({2'b00, r[j*8 +: 8]});
    end
    for (int i = 0; i < extra; i++) pkt.push_back({2'b00, 8'($urandom)});
    if (extra != 0) exp_err++;
    pkt[0][9] = 1'b1;
    if (term) pkt[pkt.size()-1][8] = 1'b1;
  endtask

  task automatic build_bad(input int len);
    logic [7:0] b;
    b = 8'($urandom);
    if (b == MAGIC) b = 8'h77;
    pkt.delete();
    pkt.push_back({2'b10, b});
    for (int i = 0; i < len; i++) pkt.push_back({2'b00, 8'($urandom)});
    pkt[pkt.size()-1][8] = 1'b1;
    exp_err++;
  endtask

  task automatic wait_drain(input string nm);
    int g = 0;
    repeat (3) @(negedge clk);
    while ((exp_q.size() != 0 || o_busy) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check({nm, "_drain"}, g < 5000, 1);
    check({nm, "_err"}, o_err_cnt, (exp_err > 255) ? 255 : exp_err);
  endtask

  initial begin
    int target, g;
    bit trunc;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("rst_ready", o_ready, 1);
    check("rst_wren", o_cmd_wren, 0);
    check("rst_busy", o_busy, 0);
    check("rst_addr", o_cmd_addr, 0);
    check("rst_data", o_cmd_data, 0);
    check("rst_err", o_err_cnt, 0);
    rst = 0;
    @(negedge clk);

    // 1: single record, latency and width
    pkt.delete();
    pkt = '{10'h25A, 10'h001, 10'h023, 10'h0DE, 10'h0AD, 10'h0BE, 10'h1EF};
    exp_q.push_back(48'h0123_DEADBEEF);
    send_pkt(0);
    wait_drain("t1");
    check("t1_latency", last_rise - last_acc, 3);
    check("t1_count", rise_cnt, 1);

    // 2: three records back to back
    build_good(3, 0, 1);
    send_pkt(0);
    wait_drain("t2");
    check("t2_count", rise_cnt, 4);

    // 3: bad magic, then a good packet
    build_bad(6);
    send_pkt(0);
    build_good(1, 0, 1);
    send_pkt(0);
    wait_drain("t3");

    // 4: trailing partial record
    build_good(1, 3, 1);
    send_pkt(0);
    wait_drain("t4");

    // 5: backpressure with FIFO overflow pressure
    saw_full = 0;
    tput_prev = 0;
    tput_chk = 1;
    build_good(DEPTH + 4, 0, 1);
    send_pkt(0);
    wait_drain("t5");
    tput_chk = 0;
    check("t5_ready_low", saw_full, 1);

    // 6: reset during strobe of record 2
    build_good(3, 0, 1);
    target = rise_cnt + 2;
    send_pkt(0);
    g = 0;
    while (rise_cnt < target && g < 2000) begin @(negedge clk); g++; end
    check("t6_reach_rec2", rise_cnt, target);
    rst = 1;
    @(negedge clk);
    check("t6_wren", o_cmd_wren, 0);
    check("t6_busy", o_busy, 0);
    check("t6_addr", o_cmd_addr, 0);
    check("t6_data", o_cmd_data, 0);
    check("t6_err", o_err_cnt, 0);
    check("t6_ready", o_ready, 1);
    rst = 0;
    exp_err = 0;
    @(negedge clk);
    build_good(3, 0, 1);
    send_pkt(0);
    wait_drain("t6_resend");

    // Random packets, bubbles and inter-packet noise
    for (int p = 0; p < 40; p++) begin
      trunc = 0;
      if ($urandom_range(0, 5) == 0) build_bad($urandom_range(0, 7));
      else begin
        trunc = (p != 39) && ($urandom_range(0, 4) == 0);
        build_good($urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0, !trunc);
      end
      send_pkt(1);
      if (!trunc) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) send_byte(8'($urandom), 1'b0, 1'($urandom));
        i_valid = 0;
      end
    end
    wait_drain("random");

    // Error counter saturation
    for (int k = 0; k < 300; k++) send_byte(8'h77, 1'b1, 1'b1);
    i_valid = 0;
    exp_err += 300;
    wait_drain("saturate");
    check("sat_value", o_err_cnt, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
